cipher_sequencer: RTL and testbench

//  Sequences the stream-cipher datapath for one request/acknowledge transaction.

---
 rtl/types_pkg.sv | 30 +++
 rtl/cipher_sequencer_if.sv | 32 +++
 rtl/cipher_sequencer_round_counter.sv | 44 ++++
 rtl/cipher_sequencer.sv | 139 +++++++++++++
 tb/tb_cipher_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/types_pkg.sv
// ---------------------------------------------------------------------------
//  types_pkg : shared enums for the interface FSM and the cipher sequencer
//  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package types_pkg;

    typedef enum logic [1:0] {
        I_IDLE       = 2'd0,
        I_PROCESSING = 2'd1,
        I_DONE       = 2'd2
    } interface_state_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WARMUP = 3'd2,
        S_GEN    = 3'd3,
        S_HOLD   = 3'd4
    } sched_state_t;

    // Byte-slot index width; a single-byte block still needs one bit.
    function automatic int unsigned bi_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cipher_sequencer_if.sv
// ---------------------------------------------------------------------------
//  cipher_sequencer_if : request state in, core/holder strobes out
//  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cipher_sequencer_if #(
    parameter int BLOCK_BYTES = 4
) ();
    localparam int BI_W = types_pkg::bi_width(BLOCK_BYTES);

    types_pkg::interface_state_t interface_state;
    logic                        core_stall;
    logic                        core_load;
    logic                        core_step;
    logic                        byte_en;
    logic [BI_W-1:0]             byte_index;
    logic                        output_is_ready;
    logic                        busy;

    modport master (
        output interface_state, core_stall,
        input  core_load, core_step, byte_en, byte_index, output_is_ready, busy
    );

    modport slave (
        input  interface_state, core_stall,
        output core_load, core_step, byte_en, byte_index, output_is_ready, busy
    );
endinterface

`default_nettype wire

// File: rtl/cipher_sequencer_round_counter.sv
// ---------------------------------------------------------------------------
//  cipher_sequencer_round_counter : saturating round/byte counter with TC flag
//  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cipher_sequencer_round_counter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             nrst,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    input  wire logic [CNT_W-1:0] last_i,
    output logic      [CNT_W-1:0] cnt_o,
    output logic                  tc_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Holds at the terminal value rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tc_o  = (cnt_q >= last_i);
    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cipher_sequencer.sv
// ---------------------------------------------------------------------------
//  cipher_sequencer : load / warm-up / generate / hold sequencing of the
//  keystream core for one request transaction.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cipher_sequencer
    import types_pkg::*;
#(
    parameter int WARMUP_ROUNDS = 16,
    parameter int BLOCK_BYTES   = 4,
    parameter int CNT_W         = 8
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    cipher_sequencer_if.slave seq_if
);
    localparam int BI_W = bi_width(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] c_WARM_LAST =
        CNT_W'((WARMUP_ROUNDS > 0) ? WARMUP_ROUNDS - 1 : 0);
    localparam logic [CNT_W-1:0] c_GEN_LAST  =
        CNT_W'((BLOCK_BYTES > 0) ? BLOCK_BYTES - 1 : 0);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic             abort;
    logic             stall;

    assign abort    = (seq_if.interface_state == I_IDLE);
    assign stall    = seq_if.core_stall;
    assign cnt_last = (state_q == S_GEN) ? c_GEN_LAST : c_WARM_LAST;

    cipher_sequencer_round_counter #(
        .CNT_W (CNT_W)
    ) u_round_counter (
        .clk    (clk),
        .nrst   (nrst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_i (cnt_last),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (seq_if.interface_state == I_PROCESSING) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_clr = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    state_d = (WARMUP_ROUNDS == 0) ? S_GEN : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else if (!stall) begin
                    if (cnt_tc) begin
                        state_d = S_GEN;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            S_GEN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else if (!stall) begin
                    if (cnt_tc) begin
                        state_d = S_HOLD;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            // A fresh request while holding is ignored until I_IDLE is seen.
            S_HOLD: begin
                cnt_clr = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        seq_if.core_load       = 1'b0;
        seq_if.core_step       = 1'b0;
        seq_if.byte_en         = 1'b0;
        seq_if.byte_index      = '0;
        seq_if.output_is_ready = 1'b0;
        seq_if.busy            = (state_q != S_IDLE);
        case (state_q)
            S_LOAD:   seq_if.core_load = !stall;
            S_WARMUP: seq_if.core_step = !stall;
            S_GEN: begin
                seq_if.core_step  = !stall;
                seq_if.byte_en    = !stall;
                seq_if.byte_index = BI_W'(cnt);
            end
            S_HOLD:   seq_if.output_is_ready = 1'b1;
            default:  ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cipher_sequencer.sv
// ---------------------------------------------------------------------------
//  tb_cipher_sequencer : default build and a W=0/B=1 build driven in lockstep,
//  compared each cycle against a timeline model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cipher_sequencer;
    import types_pkg::*;

    localparam int W0 = 16;
    localparam int B0 = 4;
    localparam int W1 = 0;
    localparam int B1 = 1;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    cipher_sequencer_if #(.BLOCK_BYTES(B0)) if0 ();
    cipher_sequencer_if #(.BLOCK_BYTES(B1)) if1 ();

    cipher_sequencer #(.WARMUP_ROUNDS(W0), .BLOCK_BYTES(B0), .CNT_W(8)) dut0 (
        .clk    (clk),
        .nrst   (nrst),
        .seq_if (if0)
    );

    cipher_sequencer #(.WARMUP_ROUNDS(W1), .BLOCK_BYTES(B1), .CNT_W(8)) dut1 (
        .clk    (clk),
        .nrst   (nrst),
        .seq_if (if1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    // Model position on the transaction timeline: 0 idle, 1 load,
    // 2..1+W warm-up, 2+W..1+W+B bytes, 2+W+B holding ready.
    int prog0 = 0;
    int prog1 = 0;

    int load0, fb0, rdy0, steps0;
    int load1, fb1, rdy1, nb1;
    int bq0[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic int advance(input int p, input int w, input int b,
                                   input interface_state_t s, input logic st);
        if (p == 0)           return (s == I_PROCESSING) ? 1 : 0;
        if (s == I_IDLE)      return 0;
        if (p <= 1 + w + b && !st) return p + 1;
        return p;
    endfunction

    task automatic check_dut(input string nm, input int p, input int w, input int b,
                             input logic st, input logic ld, input logic stp,
                             input logic be, input int idx, input logic rdy,
                             input logic bsy);
        logic gen;
        gen = (p >= 2 + w) && (p <= 1 + w + b);
        chk({nm, ".core_load"},       32'(ld),  32'(p == 1 && !st));
        chk({nm, ".core_step"},       32'(stp), 32'(p >= 2 && p <= 1 + w + b && !st));
        chk({nm, ".byte_en"},         32'(be),  32'(gen && !st));
        chk({nm, ".byte_index"},      32'(idx), gen ? 32'(p - 2 - w) : 32'd0);
        chk({nm, ".output_is_ready"}, 32'(rdy), 32'(p == 2 + w + b));
        chk({nm, ".busy"},            32'(bsy), 32'(p != 0));
    endtask

    task automatic check_all(input logic st);
        check_dut("d0", prog0, W0, B0, st, if0.core_load, if0.core_step, if0.byte_en,
                  int'(if0.byte_index), if0.output_is_ready, if0.busy);
        check_dut("d1", prog1, W1, B1, st, if1.core_load, if1.core_step, if1.byte_en,
                  int'(if1.byte_index), if1.output_is_ready, if1.busy);
    endtask

    task automatic clr_trk();
        load0 = -1; fb0 = -1; rdy0 = -1; steps0 = 0;
        load1 = -1; fb1 = -1; rdy1 = -1; nb1 = 0;
        bq0.delete();
    endtask

    task automatic track();
        if (if0.core_load && load0 < 0) load0 = cyc_n;
        if (if0.core_step) steps0++;
        if (if0.byte_en) begin
            bq0.push_back(int'(if0.byte_index));
            if (fb0 < 0) fb0 = cyc_n;
        end
        if (if0.output_is_ready && rdy0 < 0) rdy0 = cyc_n;
        if (if1.core_load && load1 < 0) load1 = cyc_n;
        if (if1.byte_en) begin
            nb1++;
            if (fb1 < 0) fb1 = cyc_n;
        end
        if (if1.output_is_ready && rdy1 < 0) rdy1 = cyc_n;
    endtask

    task automatic cyc(input interface_state_t s, input logic st);
        if0.interface_state = s;
        if1.interface_state = s;
        if0.core_stall      = st;
        if1.core_stall      = st;
        @(negedge clk);
        check_all(st);
        track();
        @(posedge clk);
        prog0 = advance(prog0, W0, B0, s, st);
        prog1 = advance(prog1, W1, B1, s, st);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #2;
        prog0 = 0;
        prog1 = 0;
        check_all(if0.core_stall);
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic check_seq(input string tag);
        chk({tag, ".nbytes"}, 32'(bq0.size()), 32'(B0));
        foreach (bq0[i]) chk({tag, ".seq"}, 32'(bq0[i]), 32'(i));
    endtask

    initial begin
        int n0;
        interface_state_t s;
        logic st;
        int r;

        if0.interface_state = I_IDLE;
        if1.interface_state = I_IDLE;
        if0.core_stall      = 1'b0;
        if1.core_stall      = 1'b0;
        clr_trk();
        do_reset();

        // Nominal request on both builds.
        cyc(I_IDLE, 1'b0);
        clr_trk();
        n0 = cyc_n;
        cyc(I_PROCESSING, 1'b0);
        repeat (24) cyc(I_PROCESSING, 1'b0);
        chk("nom.load_at",  32'(load0 - n0), 32'd1);
        chk("nom.byte_at",  32'(fb0 - n0),   32'd18);
        chk("nom.steps",    32'(steps0),     32'd20);
        chk("nom.ready_at", 32'(rdy0 - n0),  32'd22);
        check_seq("nom");
        chk("w0.load_at",   32'(load1 - n0), 32'd1);
        chk("w0.byte_at",   32'(fb1 - n0),   32'd2);
        chk("w0.nbytes",    32'(nb1),        32'd1);
        chk("w0.ready_at",  32'(rdy1 - n0),  32'd3);

        // Back-to-back: done, one idle cycle, then a fresh request.
        repeat (3) cyc(I_DONE, 1'b0);
        cyc(I_IDLE, 1'b0);
        clr_trk();
        n0 = cyc_n;
        cyc(I_PROCESSING, 1'b0);
        repeat (24) cyc(I_PROCESSING, 1'b0);
        chk("b2b.load_at",  32'(load0 - n0), 32'd1);
        chk("b2b.ready_at", 32'(rdy0 - n0),  32'd22);
        check_seq("b2b");

        // Stalls: three in warm-up, one on the second byte.
        cyc(I_IDLE, 1'b0);
        clr_trk();
        n0 = cyc_n;
        cyc(I_PROCESSING, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            cyc(I_PROCESSING, (i >= 5 && i <= 7) || i == 22);
        end
        chk("stall.ready_at", 32'(rdy0 - n0), 32'd26);
        chk("stall.steps",    32'(steps0),    32'd20);
        check_seq("stall");

        // Abort while byte 1 is on the bus.
        cyc(I_IDLE, 1'b0);
        clr_trk();
        n0 = cyc_n;
        cyc(I_PROCESSING, 1'b0);
        repeat (18) cyc(I_PROCESSING, 1'b0);
        chk("abort.idx_before", 32'(if0.byte_index), 32'd1);
        chk("abort.en_before",  32'(if0.byte_en),    32'd1);
        cyc(I_IDLE, 1'b0);
        chk("abort.byte_en", 32'(if0.byte_en), 32'd0);
        chk("abort.busy",    32'(if0.busy),    32'd0);
        repeat (3) cyc(I_IDLE, 1'b0);
        chk("abort.nbytes", 32'(bq0.size()), 32'd2);

        // Reset asserted mid-generation, then a clean restart.
        cyc(I_PROCESSING, 1'b0);
        repeat (19) cyc(I_PROCESSING, 1'b0);
        do_reset();
        chk("rst.busy", 32'(if0.busy), 32'd0);
        clr_trk();
        n0 = cyc_n;
        cyc(I_PROCESSING, 1'b0);
        repeat (5) cyc(I_PROCESSING, 1'b0);
        chk("rst.load_at", 32'(load0 - n0), 32'd1);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            s = (r < 8) ? I_IDLE : (r < 80) ? I_PROCESSING : I_DONE;
            st = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end
            cyc(s, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
